// File: rtl/mlaccel_memarb.sv
// mlaccel_memarb: N-client arbiter and response tracker for the shared accelerator main memory.
// Latency: grant in the request cycle, memory command registered next edge, rsp_valid RD_LAT+1 cycles after grant.
// Backpressure: req_ready is a combinational one-hot grant; client 0 always wins, clients 1..N-1 keep one transaction in flight.
// Build option: define MLACCEL_MEMARB_RR_EN for round-robin among clients 1..N-1 (default: fixed priority, lowest index wins).
module mlaccel_memarb #(
   parameter int  NCLIENTS = 3,
   parameter int  ADDR_W   = 16,
   parameter int  DATA_W   = 64,
   parameter int  RD_LAT   = 1,
   localparam int BE_W     = DATA_W / 8
) (
   input  logic                         clock,
   input  logic                         resetn,
   input  logic [NCLIENTS-1:0]          req_valid,
   input  logic [NCLIENTS*BE_W-1:0]     req_wen,
   input  logic [NCLIENTS*ADDR_W-1:0]   req_addr,
   input  logic [NCLIENTS*DATA_W-1:0]   req_wdata,
   output logic [NCLIENTS-1:0]          req_ready,
   output logic [NCLIENTS-1:0]          rsp_valid,
   output logic [DATA_W-1:0]            rsp_rdata,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic [BE_W-1:0]              mem_wen,
   output logic [DATA_W-1:0]            mem_wdata,
   input  logic [DATA_W-1:0]            mem_rdata
);

   localparam int PTR_W = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1;

   // One-hot grant, index of the granted client, and "some client granted".
   logic [NCLIENTS-1:0]          grant;
   logic [PTR_W-1:0]             gnt_idx;
   logic                         gnt_any;

   // Per-client grant history; a client is in flight while any stage is set,
   // which also covers its rsp_valid cycle (last stage).
   logic [NCLIENTS-1:0][RD_LAT:0] rsp_pipe;

`ifdef MLACCEL_MEMARB_RR_EN
   logic [PTR_W-1:0]             rr_ptr;
   logic [PTR_W-1:0]             cand;

   // Grant: client 0 first, else round-robin search over 1..N-1 starting at rr_ptr.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      if (resetn) begin
         if (req_valid[0]) begin
            grant[0] = 1'b1;
            gnt_any  = 1'b1;
         end else begin
            for (int j = 0; j < NCLIENTS - 1; j++) begin
               cand = PTR_W'(((int'(rr_ptr) - 1 + j) % (NCLIENTS - 1)) + 1);
               if (!gnt_any && req_valid[cand] && !(|rsp_pipe[cand])) begin
                  grant[cand] = 1'b1;
                  gnt_idx     = cand;
                  gnt_any     = 1'b1;
               end
            end
         end
      end
   end

   // Round-robin pointer advances past a granted low-priority client, holds otherwise.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rr_ptr <= PTR_W'(1);
      end else if (gnt_any && (gnt_idx != '0)) begin
         rr_ptr <= (int'(gnt_idx) == NCLIENTS - 1) ? PTR_W'(1) : gnt_idx + 1'b1;
      end
   end
`else
   // Grant: client 0 first, else lowest-index eligible client in 1..N-1.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      if (resetn) begin
         if (req_valid[0]) begin
            grant[0] = 1'b1;
            gnt_any  = 1'b1;
         end else begin
            for (int c = 1; c < NCLIENTS; c++) begin
               if (!gnt_any && req_valid[c] && !(|rsp_pipe[c])) begin
                  grant[c] = 1'b1;
                  gnt_idx  = PTR_W'(c);
                  gnt_any  = 1'b1;
               end
            end
         end
      end
   end
`endif

   assign req_ready = grant;

   // Register the granted client's command; idle cycles issue no write, address/data hold.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         mem_addr  <= '0;
         mem_wen   <= '0;
         mem_wdata <= '0;
      end else begin
         mem_wen <= '0;
         if (gnt_any) begin
            mem_addr  <= req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
            mem_wen   <= req_wen[int'(gnt_idx)*BE_W +: BE_W];
            mem_wdata <= req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
         end
      end
   end

   // Shift each client's grant bit through RD_LAT+1 stages to time its response.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rsp_pipe <= '0;
      end else begin
         for (int i = 0; i < NCLIENTS; i++) begin
            rsp_pipe[i] <= {rsp_pipe[i][RD_LAT-1:0], grant[i]};
         end
      end
   end

   // Response strobe is the last stage of each client's pipe.
   always_comb begin
      rsp_valid = '0;
      for (int i = 0; i < NCLIENTS; i++) begin
         rsp_valid[i] = rsp_pipe[i][RD_LAT];
      end
   end

   assign rsp_rdata = mem_rdata;

endmodule

// File: doc/mlaccel_memarb.md
# mlaccel_memarb

Parametrised arbiter and response tracker for the shared 64-bit main memory of the ML accelerator. It replaces the fixed three-way compute/QPI/sequencer memory mux with an N-client arbiter. Client 0 always has strict priority and full throughput; clients 1..N-1 share the remaining slots by fixed priority or round-robin. Per-client response strobes are timed by a configurable read latency. It sits between the command/sequencer/compute blocks and `mlaccel_memory`.

## Interface
- `NCLIENTS`, 3: number of clients, 2..8; client 0 is the high-priority compute port.
- `ADDR_W`, 16: word address width.
- `DATA_W`, 64: data width; must be a multiple of 8; `BE_W = DATA_W/8`.
- `RD_LAT`, 1: memory cycles from registered `mem_addr` to valid `mem_rdata`, 1..4.

Ports:
- `clock`  in  1  single clock, all logic on rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `req_valid`  in  NCLIENTS  per-client request.
- `req_wen`  in  NCLIENTS*BE_W  per-client byte write enables; all-zero = read.
- `req_addr`  in  NCLIENTS*ADDR_W  per-client address, client i at slice i.
- `req_wdata`  in  NCLIENTS*DATA_W  per-client write data.
- `req_ready`  out  NCLIENTS  combinational one-hot grant; request accepted when valid&ready.
- `rsp_valid`  out  NCLIENTS  one-cycle done strobe per accepted request (read or write).
- `rsp_rdata`  out  DATA_W  shared read data, valid when any `rsp_valid` bit is high.
- `mem_addr`  out  ADDR_W  registered memory address.
- `mem_wen`  out  BE_W  registered memory byte enables.
- `mem_wdata`  out  DATA_W  registered memory write data.
- `mem_rdata`  in  DATA_W  memory read data.

## Operation
- Grant, in the same cycle:
  - If `req_valid[0]`, grant client 0.
  - Otherwise grant one eligible client in 1..N-1.
  - Eligible = `req_valid[i]` and no transaction of client i in flight.
  - At most one `req_ready` bit is high; never high without the matching `req_valid`.
- Client 0 has no in-flight limit and may be granted every cycle.
- Clients 1..N-1 have one outstanding transaction each. After a grant, client i is ineligible until the cycle after its `rsp_valid[i]`.
- On grant, the granted slices are registered into `mem_addr`, `mem_wen`, `mem_wdata` at the next edge.
- With no grant, `mem_wen` registers 0. `mem_addr` and `mem_wdata` hold their previous values.
- Response tracking:
  - Per-client shift register, depth RD_LAT+1, input = grant bit.
  - `rsp_valid[i]` = last stage.
  - `rsp_rdata` = `mem_rdata` passed through combinationally.
- Requests are not latched. A client must hold `req_valid` and its payload until granted; withdrawing before grant is legal and has no effect.
- Low-priority clients may starve while client 0 requests continuously. This is intended.
- Reset: asynchronous clear of all tracking registers, `mem_wen`, `mem_addr` and `mem_wdata` to 0, and the round-robin pointer to 1.
  - While `resetn` is low, `req_ready` is 0.
  - `rsp_valid` is 0 during reset and after release until new grants occur.
  - In-flight transactions are dropped; no `rsp_valid` is produced for them.

## Timing
- Grant at cycle T → memory sees address/wen from cycle T+1 → `rsp_valid[i]` and `rsp_rdata` valid at cycle T+1+RD_LAT.
- With RD_LAT=1, latency is 2 cycles, so a client in 1..N-1 can issue at most every 3 cycles.
- Writes take effect at T+1 and are acknowledged at T+1+RD_LAT. A read to the same address granted at T+1 or later returns the new data.
- Back-to-back client-0 grants produce back-to-back `rsp_valid[0]` in the same order.
- Responses of different clients never collide: one grant per cycle gives one response per cycle.
- Simultaneous own-response and new request: client i is ineligible in its `rsp_valid` cycle and eligible one cycle later.

## Configuration
- `MLACCEL_MEMARB_RR_EN` defined: round-robin among clients 1..N-1.
  - Search starts at the pointer, wrapping N-1 → 1.
  - After granting client k≥1, the pointer becomes k+1 (wrapping to 1).
  - The pointer holds on no grant or a client-0 grant.
- Not defined: fixed priority, lowest eligible index wins (legacy behaviour). The pointer is absent.

## Test plan
- Single read, RD_LAT=1: client 1 reads addr 0x0010 (memory holds 0x1122334455667788) at T → `mem_addr`=0x0010, `mem_wen`=0 at T+1; `rsp_valid`=3'b010 and `rsp_rdata`=0x1122334455667788 at T+2.
- Priority: clients 0, 1, 2 all request at T → `req_ready`=3'b001 for every cycle client 0 holds `req_valid`; client 1 is granted the first cycle client 0 drops.
- Round-robin (macro on, NCLIENTS=4): clients 1..3 request continuously → grant order 1,2,3,1,… with respect to the in-flight block. Macro off → client 1 is granted at every eligibility.
- Write then read: client 2 writes wen=8'h0F, data 0xAAAA_BBBB_CCCC_DDDD to 0x0100; after `rsp_valid[2]` it reads 0x0100 → low 32 bits read back as 0xCCCCDDDD, upper bytes unchanged.
- Client-0 streaming, RD_LAT=3: 8 consecutive reads of 0x0000..0x0007 → 8 consecutive `rsp_valid[0]` pulses starting 4 cycles after the first grant, data in address order.
- Reset mid-flight: assert `resetn`=0 one cycle after a client-1 grant → no `rsp_valid` ever seen for it, `mem_wen`=0 immediately; after release, client 1 is granted again on its first request.
